// File: rtl/seg7_pkg.sv
// Shared constants and glyph lookup for the seven-segment scanner.
package seg7_pkg;

    // All segments and the decimal point off (active-low outputs).
    localparam logic [7:0] SEG_OFF   = 8'hFF;
    // Glyph bits 6:0 with every segment off, used for blanked digits.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low g..a patterns for hex digits; entry n is GLYPH_TABLE[n].
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
        7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    // Position of the scan within the current digit slot.
    typedef enum logic {
        PH_DEAD  = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

    function automatic logic [6:0] nibble_to_glyph(input logic [3:0] nib);
        return GLYPH_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot timer: dwell prescaler, digit index and DEAD/DRIVE phase.
module seg7_scan_timer
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int DEAD_CYCLES  = 2,
    parameter int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [IDX_W-1:0] digit_idx,
    output phase_t           phase
);

    localparam int               PRE_W    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0] prescaler;
    logic [PRE_W-1:0] prescaler_next;
    logic [IDX_W-1:0] digit_idx_next;

    // State register: prescaler and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            digit_idx <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, whatever the statement order.
            prescaler <= prescaler_next;
            digit_idx <= digit_idx_next;
        end
    end

    // Next state: count while enabled, advance the digit on wrap, hold otherwise.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
        prescaler_next = prescaler;
        digit_idx_next = digit_idx;
        if (enable) begin
            if (prescaler == PRE_LAST) begin
                prescaler_next = '0;
                digit_idx_next = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            end else begin
                prescaler_next = prescaler + 1'b1;
            end
        end
    end

    // Phase output: the first DEAD_CYCLES counts of each slot are dark.
    generate
        if (DEAD_CYCLES == 0) begin : g_no_dead
            assign phase = PH_DRIVE;
        end else begin : g_dead
            always_comb begin
                phase = (prescaler < PRE_W'(DEAD_CYCLES)) ? PH_DEAD : PH_DRIVE;
            end
        end
    endgenerate

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment driver with leading-zero blanking.
module seven_segment_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int DEAD_CYCLES  = 2,
    parameter int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    enable,
    input  logic                    lz_blank,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        digit_idx
);

    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    zero_above;
    logic [3:0]              cur_nib;
    logic [7:0]              seg_next;
    logic [NUM_DIGITS-1:0]   an_next;
    phase_t                  phase;

    seg7_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .DWELL_CYCLES (DWELL_CYCLES),
        .DEAD_CYCLES  (DEAD_CYCLES),
        .IDX_W        (IDX_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .digit_idx (digit_idx),
        .phase     (phase)
    );

    // Shadow registers: capture the display data on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: shadows are reset so the first slots after reset show 0, never X.
            value_q <= '0;
            dp_q    <= '0;
        end else if (load) begin
            value_q <= value;
            dp_q    <= dp;
        end
    end

    // Blanking mask: digit i is dark when it and every higher nibble are zero.
    always_comb begin
        zero_above = lz_blank;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above    = zero_above && (value_q[4*i +: 4] == 4'h0);
            blank_mask[i] = zero_above && (i != 0);
        end
    end

    // Output decode for the current slot; dark when disabled or in dead time.
    always_comb begin
        seg_next = SEG_OFF;
        an_next  = '1;
        cur_nib  = value_q[{digit_idx, 2'b00} +: 4];
        if (enable && (phase == PH_DRIVE)) begin
            an_next[digit_idx] = 1'b0;
            seg_next = {~dp_q[digit_idx],
                        blank_mask[digit_idx] ? SEG_BLANK : nibble_to_glyph(cur_nib)};
        end
    end

    // Output register: one cycle of latency, glitch-free pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            an  <= '1;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule
